ternary_neuron_accum: RTL and testbench
=======================================

// Module: ternary_neuron_accum
// PURPOSE
//  Consumes popcount results from the popcount21 stages and forms one ternary neuron output.
//  - Each beat carries two counts: positive-weight and negative-weight inputs.
//  - Fan-in above 21 is covered by accumulating NUM_CHUNKS beats per neuron.
//  - The signed sum is compared with two thresholds and emitted as a trit over valid/ready.
//  - Sits directly downstream of the popcount array and feeds the next layer's input register.
// PARAMETERS
//  POP_W       5   width of each popcount input (unsigned)
//  NUM_CHUNKS  4   beats accumulated per neuron evaluation; range 1..16
//  ACC_W       8   signed accumulator, threshold and out_sum width
// PORTS
//  clk        in   1       clock, rising edge
//  rst_n      in   1       asynchronous active-low reset
//  flush      in   1       synchronous abort of the current frame
//  in_valid   in   1       beat valid
//  in_ready   out  1       beat accepted when in_valid & in_ready
//  in_pos     in   POP_W   popcount of inputs with weight +1
//  in_neg     in   POP_W   popcount of inputs with weight -1
//  thr_hi     in   ACC_W   signed upper threshold
//  thr_lo     in   ACC_W   signed lower threshold
//  out_valid  out  1       result valid; held until accepted
//  out_ready  in   1       result accepted when out_valid & out_ready
//  out_trit   out  2       01=+1, 11=-1, 00=0 (10 never driven)
//  out_sum    out  ACC_W   signed accumulated sum, for debug and verification
// BEHAVIOUR
//  Reset (async, rst_n=0)
//  - State IDLE; cnt, acc and out_sum are 0; out_trit=00; out_valid=0; in_ready=1.
//  States
//  - IDLE:  waiting for first beat of a frame.
//  - ACCUM: 1..NUM_CHUNKS-1 beats accepted.
//  - EMIT:  result held on outputs.
//  Input handshake
//  - in_ready = (state != EMIT), i.e. combinational from state only.
//  - Per-beat delta = $signed({1'b0,in_pos}) - $signed({1'b0,in_neg}), range +/-(2^POP_W-1).
//  - First beat accepted in IDLE:
//    - acc <= delta (no carry-in from a previous frame).
//    - thr_hi and thr_lo are sampled into internal registers; later changes do not affect this frame.
//  - Each accepted beat: acc <= sat(acc + delta), cnt <= cnt + 1.
//    - sat clamps to [-(2^(ACC_W-1)-1), +(2^(ACC_W-1)-1)].
//    - Defaults cannot overflow (max |sum| = 124); saturation must still be implemented.
//  - Accepting beat number NUM_CHUNKS moves to EMIT; cnt returns to 0.
//    - NUM_CHUNKS=1 goes IDLE->EMIT directly.
//  Output
//  - out_valid rises in the cycle after the final beat is accepted (latency 1).
//  - Registered alongside out_valid:
//    - out_sum = final acc.
//    - out_trit = +1 if sum > thr_hi; else -1 if sum < thr_lo; else 0.
//    - Signed compares; +1 wins when thr_lo > thr_hi.
//  - out_valid, out_trit and out_sum stay stable while out_valid & !out_ready.
//  - out_valid & out_ready: EMIT->IDLE; out_valid=0 next cycle; out_trit/out_sum keep last value.
//  - No beat is accepted in the same cycle as the output handshake.
//    - in_ready returns to 1 one cycle later.
//    - Minimum frame period = NUM_CHUNKS + 1 cycles.
//  Flush (synchronous, highest priority over all other events)
//  - Next cycle: state IDLE, cnt=0, acc=0, out_valid=0.
//  - A beat offered in the flush cycle is dropped.
//  - A pending result is discarded.
//  Reset mid-frame
//  - Same end state as flush, applied asynchronously.
//  in_valid=0 gaps
//  - Hold all state indefinitely; there is no timeout.
// TESTING
//  1. NUM_CHUNKS=4, thr_hi=10, thr_lo=-10; beats (pos,neg) = (20,3),(15,5),(7,7),(1,0), back-to-back
//     -> out_sum=28, out_trit=01, out_valid in the cycle after beat 4.
//  2. Beats (0,21),(0,21),(0,21),(0,21) -> out_sum=-84, out_trit=11.
//     Same frame with thr_hi=-84, thr_lo=-84 -> trit=00 (boundary values are not strictly exceeded).
//  3. out_ready=0 for 5 cycles after out_valid -> in_ready=0 and outputs stable throughout.
//     out_ready=1 -> out_valid=0 next cycle; in_ready=1 one cycle later.
//  4. thr_hi changed from 10 to 50 after beat 1 of a frame summing to 28 -> trit=01 (threshold sampled at beat 1).
//  5. flush asserted after beat 2 with in_valid=1 -> offered beat dropped.
//     A following full frame of (3,1)x4 -> out_sum=8, with no carry from the aborted frame.
//  6. rst_n pulsed low mid-frame and while out_valid=1 -> all outputs reset immediately (async).
//     Random 10k-frame run vs. reference model; check handshake ordering under random in_valid/out_ready stalls.

Source files
------------

// File: rtl/ternary_neuron_accum.sv
// ternary_neuron_accum: accumulates NUM_CHUNKS popcount beats (positive minus
// negative weight counts) into a saturating signed sum, then emits one ternary
// neuron output by comparing the sum against thresholds sampled at the frame's
// first beat.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   flush               synchronous frame abort; overrides every other event
//   in_valid/in_ready   beat handshake; in_ready is low only while a result is held
//   in_pos, in_neg      unsigned popcounts of +1 and -1 weighted inputs
//   thr_hi, thr_lo      signed thresholds, captured on the first beat of a frame
//   out_valid/out_ready result handshake; result held until accepted
//   out_trit            01 = +1, 11 = -1, 00 = 0
//   out_sum             signed final accumulated sum
module ternary_neuron_accum #(
  parameter int unsigned POP_W      = 5,
  parameter int unsigned NUM_CHUNKS = 4,
  parameter int unsigned ACC_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [POP_W-1:0] in_pos,
  input  logic [POP_W-1:0] in_neg,
  input  logic [ACC_W-1:0] thr_hi,
  input  logic [ACC_W-1:0] thr_lo,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_trit,
  output logic [ACC_W-1:0] out_sum
);

  localparam int unsigned CNT_W   = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int unsigned DELTA_W = POP_W + 1;
  localparam int unsigned SUM_W   = ((ACC_W > DELTA_W) ? ACC_W : DELTA_W) + 1;
  localparam int          SAT_MAX = (1 << (ACC_W - 1)) - 1;

  localparam logic signed [SUM_W-1:0] SAT_HI   = SUM_W'(SAT_MAX);
  localparam logic signed [SUM_W-1:0] SAT_LO   = SUM_W'(-SAT_MAX);
  localparam logic [CNT_W-1:0]        LAST_CNT = CNT_W'(NUM_CHUNKS - 1);

  localparam logic [1:0] TRIT_POS  = 2'b01;
  localparam logic [1:0] TRIT_NEG  = 2'b11;
  localparam logic [1:0] TRIT_ZERO = 2'b00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    EMIT  = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [ACC_W-1:0]   thr_hi_q, thr_hi_d;
  logic signed [ACC_W-1:0]   thr_lo_q, thr_lo_d;
  logic                      out_valid_d;
  logic [1:0]                out_trit_d;
  logic [ACC_W-1:0]          out_sum_d;

  logic signed [DELTA_W-1:0] delta;
  logic signed [ACC_W-1:0]   acc_base;
  logic signed [SUM_W-1:0]   sum_wide;
  logic signed [ACC_W-1:0]   acc_sat;
  logic signed [ACC_W-1:0]   thr_hi_eff;
  logic signed [ACC_W-1:0]   thr_lo_eff;
  logic [1:0]                trit_c;
  logic                      beat_accept;
  logic                      last_beat;
  logic                      in_idle;

  // Beats are blocked only while a result waits for acceptance.
  assign in_ready    = (state_q != EMIT);
  assign beat_accept = in_valid && in_ready;
  assign in_idle     = (state_q == IDLE);

  // Signed per-beat contribution and saturating accumulate; a new frame starts from 0.
  always_comb begin
    delta    = $signed({1'b0, in_pos}) - $signed({1'b0, in_neg});
    acc_base = in_idle ? '0 : acc_q;
    sum_wide = SUM_W'(acc_base) + SUM_W'(delta);
    if (sum_wide > SAT_HI) begin
      acc_sat = ACC_W'(SAT_HI);
    end else if (sum_wide < SAT_LO) begin
      acc_sat = ACC_W'(SAT_LO);
    end else begin
      acc_sat = ACC_W'(sum_wide);
    end
  end

  // Thresholds come straight from the ports on the first beat so NUM_CHUNKS=1 works.
  always_comb begin
    thr_hi_eff = in_idle ? $signed(thr_hi) : thr_hi_q;
    thr_lo_eff = in_idle ? $signed(thr_lo) : thr_lo_q;
    if (acc_sat > thr_hi_eff) begin
      trit_c = TRIT_POS;
    end else if (acc_sat < thr_lo_eff) begin
      trit_c = TRIT_NEG;
    end else begin
      trit_c = TRIT_ZERO;
    end
  end

  assign last_beat = in_idle ? (NUM_CHUNKS == 1) : (cnt_q == LAST_CNT);

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    thr_hi_d    = thr_hi_q;
    thr_lo_d    = thr_lo_q;
    out_valid_d = out_valid;
    out_trit_d  = out_trit;
    out_sum_d   = out_sum;

    if (flush) begin
      state_d     = IDLE;
      cnt_d       = '0;
      acc_d       = '0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          if (beat_accept) begin
            acc_d = acc_sat;
            if (in_idle) begin
              thr_hi_d = $signed(thr_hi);
              thr_lo_d = $signed(thr_lo);
            end
            if (last_beat) begin
              state_d     = EMIT;
              cnt_d       = '0;
              out_valid_d = 1'b1;
              out_sum_d   = acc_sat;
              out_trit_d  = trit_c;
            end else begin
              state_d = ACCUM;
              cnt_d   = cnt_q + CNT_W'(1);
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
          end
        end
        default: begin
          state_d     = IDLE;
          cnt_d       = '0;
          acc_d       = '0;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      thr_hi_q  <= '0;
      thr_lo_q  <= '0;
      out_valid <= 1'b0;
      out_trit  <= TRIT_ZERO;
      out_sum   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      thr_hi_q  <= thr_hi_d;
      thr_lo_q  <= thr_lo_d;
      out_valid <= out_valid_d;
      out_trit  <= out_trit_d;
      out_sum   <= out_sum_d;
    end
  end

endmodule

// File: tb/tb_ternary_neuron_accum.sv
// Bench for ternary_neuron_accum: table-driven frames plus hand-written stall,
// threshold-sampling, flush and async-reset sequences, then a randomised run.
// A second instance with a 6-bit accumulator exercises saturation.
module tb_ternary_neuron_accum;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic [4:0] in_pos = '0;
  logic [4:0] in_neg = '0;
  logic [7:0] thr_hi = '0;
  logic [7:0] thr_lo = '0;

  logic       in_ready, out_valid;
  logic [1:0] out_trit;
  logic [7:0] out_sum;
  logic       in_ready6, out_valid6;
  logic [1:0] out_trit6;
  logic [5:0] out_sum6;

  ternary_neuron_accum #(.POP_W(5), .NUM_CHUNKS(4), .ACC_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pos(in_pos), .in_neg(in_neg),
    .thr_hi(thr_hi), .thr_lo(thr_lo),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_trit(out_trit), .out_sum(out_sum)
  );

  ternary_neuron_accum #(.POP_W(5), .NUM_CHUNKS(4), .ACC_W(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready6),
    .in_pos(in_pos), .in_neg(in_neg),
    .thr_hi(thr_hi[5:0]), .thr_lo(thr_lo[5:0]),
    .out_valid(out_valid6), .out_ready(out_ready),
    .out_trit(out_trit6), .out_sum(out_sum6)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string name;
    int    hi;
    int    lo;
    int    p[4];
    int    n[4];
    int    exp_sum;
    int    exp_trit;
    int    exp_sum6;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int m);
    if (v > m) return m;
    if (v < -m) return -m;
    return v;
  endfunction

  function automatic int trit_of(input int s, input int hi, input int lo);
    if (s > hi) return 1;
    if (s < lo) return 3;
    return 0;
  endfunction

  function automatic int sx6(input logic [7:0] t);
    logic signed [5:0] t6;
    t6 = t[5:0];
    return int'(t6);
  endfunction

  function automatic vec_t mk(input string name, input int hi, input int lo,
                              input int p0, input int n0, input int p1, input int n1,
                              input int p2, input int n2, input int p3, input int n3,
                              input int es, input int et, input int e6);
    vec_t v;
    v.name = name; v.hi = hi; v.lo = lo;
    v.p[0] = p0; v.n[0] = n0; v.p[1] = p1; v.n[1] = n1;
    v.p[2] = p2; v.n[2] = n2; v.p[3] = p3; v.n[3] = n3;
    v.exp_sum = es; v.exp_trit = et; v.exp_sum6 = e6;
    return v;
  endfunction

  // Offer one beat from a negedge; returns on the negedge after it is accepted.
  task automatic send_beat(input int p, input int n);
    int k;
    in_valid = 1'b1;
    in_pos   = 5'(p);
    in_neg   = 5'(n);
    k = 0;
    while (!in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) chk("beat_ready_timeout", int'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Called on the negedge right after the final beat: checks latency-1 result.
  task automatic collect(input string name, input int es, input int et,
                         input logic [7:0] hi8, input logic [7:0] lo8, input int e6);
    chk({name, "_valid"}, int'(out_valid), 1);
    chk({name, "_sum"}, int'($signed(out_sum)), es);
    chk({name, "_trit"}, int'(out_trit), et);
    chk({name, "_valid6"}, int'(out_valid6), 1);
    chk({name, "_sum6"}, int'($signed(out_sum6)), e6);
    chk({name, "_trit6"}, int'(out_trit6), trit_of(e6, sx6(hi8), sx6(lo8)));
    chk({name, "_ready_in_emit"}, int'(in_ready), 0);
    if (out_ready) begin
      @(negedge clk);
      chk({name, "_valid_drop"}, int'(out_valid), 0);
      chk({name, "_ready_back"}, int'(in_ready), 1);
      chk({name, "_sum_kept"}, int'($signed(out_sum)), es);
    end
  endtask

  task automatic run_vec(input vec_t v);
    thr_hi    = 8'(v.hi);
    thr_lo    = 8'(v.lo);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send_beat(v.p[i], v.n[i]);
    collect(v.name, v.exp_sum, v.exp_trit, 8'(v.hi), 8'(v.lo), v.exp_sum6);
  endtask

  initial begin
    vec_t f1, f31;
    // name, hi, lo, beats (p,n)x4, sum, trit, sum with 6-bit accumulator
    vecs.push_back(mk("basic28",   10, -10, 20,3, 15,5, 7,7, 1,0,    28, 1,  28));
    vecs.push_back(mk("neg84",     10, -10, 0,21, 0,21, 0,21, 0,21, -84, 3, -31));
    vecs.push_back(mk("thr_eq84", -84, -84, 0,21, 0,21, 0,21, 0,21, -84, 0, -31));
    vecs.push_back(mk("pos_max",   10, -10, 31,0, 31,0, 31,0, 31,0, 124, 1,  31));
    vecs.push_back(mk("neg_max",   10, -10, 0,31, 0,31, 0,31, 0,31,-124, 3, -31));
    vecs.push_back(mk("sat_back",  10, -10, 31,0, 31,0, 0,31, 0,5,    26, 1,  -5));
    vecs.push_back(mk("zero",       5,  -5, 2,2, 2,2, 2,2, 2,2,        0, 0,   0));
    vecs.push_back(mk("lo_gt_hi",  -5,   5, 1,0, 1,0, 1,0, 1,0,        4, 1,   4));
    vecs.push_back(mk("lo_gt_hi_n",-5,   5, 0,2, 0,2, 0,2, 0,0,       -6, 3,  -6));
    vecs.push_back(mk("hi_eq28",   28, -10, 20,3, 15,5, 7,7, 1,0,    28, 0,  28));
    vecs.push_back(mk("hi_27",     27, -10, 20,3, 15,5, 7,7, 1,0,    28, 1,  28));
    vecs.push_back(mk("lo_85",    100, -84, 0,22, 0,21, 0,21, 0,21, -85, 3, -31));
    f1  = vecs[0];
    f31 = mk("clean", 10, -10, 3,1, 3,1, 3,1, 3,1, 8, 0, 8);

    // Reset state
    #1;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_ready", int'(in_ready), 1);
    chk("rst_sum", int'(out_sum), 0);
    chk("rst_trit", int'(out_trit), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Back-pressure: result held, beats blocked, no beat taken on the handshake cycle
    thr_hi = 8'(10); thr_lo = 8'(-10);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_beat(f1.p[i], f1.n[i]);
    for (int s = 0; s < 5; s++) begin
      chk("stall_valid", int'(out_valid), 1);
      chk("stall_ready", int'(in_ready), 0);
      chk("stall_sum", int'($signed(out_sum)), 28);
      chk("stall_trit", int'(out_trit), 1);
      in_valid = 1'b1; in_pos = 5'd9; in_neg = 5'd0;
      @(negedge clk);
    end
    out_ready = 1'b1;
    collect("stall_release", 28, 1, 8'(10), 8'(-10), 28);
    in_valid = 1'b0;
    run_vec(f1);

    // Thresholds are sampled on the first beat only
    thr_hi = 8'(10); thr_lo = 8'(-10);
    send_beat(20, 3);
    thr_hi = 8'(50);
    thr_lo = 8'(40);
    for (int i = 1; i < 4; i++) send_beat(f1.p[i], f1.n[i]);
    collect("thr_sampled", 28, 1, 8'(10), 8'(-10), 28);

    // Flush mid-frame drops the offered beat and clears the accumulator
    send_beat(20, 0);
    send_beat(20, 0);
    in_valid = 1'b1; in_pos = 5'd31; in_neg = 5'd0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", int'(out_valid), 0);
    chk("flush_ready", int'(in_ready), 1);
    run_vec(f31);

    // Flush discards a pending result
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_beat(f1.p[i], f1.n[i]);
    chk("flush_pend_valid_pre", int'(out_valid), 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_pend_valid", int'(out_valid), 0);
    chk("flush_pend_ready", int'(in_ready), 1);
    out_ready = 1'b1;
    run_vec(f31);

    // Async reset mid-frame
    send_beat(20, 0);
    send_beat(20, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_mid_ready", int'(in_ready), 1);
    chk("arst_mid_sum", int'(out_sum), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(f31);

    // Async reset while a result is held
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_beat(f1.p[i], f1.n[i]);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_emit_valid", int'(out_valid), 0);
    chk("arst_emit_sum", int'(out_sum), 0);
    chk("arst_emit_trit", int'(out_trit), 0);
    chk("arst_emit_ready", int'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    run_vec(f1);

    // Random frames with input gaps and output stalls against a reference model
    for (int f = 0; f < 300; f++) begin
      logic [7:0] hi8, lo8;
      int acc8, acc6, stall;
      hi8 = 8'($urandom_range(0, 255));
      lo8 = 8'($urandom_range(0, 255));
      thr_hi = hi8; thr_lo = lo8;
      acc8 = 0; acc6 = 0;
      stall = $urandom_range(0, 3);
      for (int b = 0; b < 4; b++) begin
        int p, n, gap;
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          chk("rand_gap_valid", int'(out_valid), 0);
          chk("rand_gap_ready", int'(in_ready), 1);
        end
        p = $urandom_range(0, 31);
        n = $urandom_range(0, 31);
        if (b == 3) out_ready = (stall == 0);
        send_beat(p, n);
        acc8 = sat(acc8 + p - n, 127);
        acc6 = sat(acc6 + p - n, 31);
        if (b == 0) begin
          thr_hi = 8'($urandom_range(0, 255));
          thr_lo = 8'($urandom_range(0, 255));
        end
      end
      for (int s = 0; s < stall; s++) begin
        chk("rand_stall_valid", int'(out_valid), 1);
        chk("rand_stall_ready", int'(in_ready), 0);
        chk("rand_stall_sum", int'($signed(out_sum)), acc8);
        in_valid = 1'b1; in_pos = 5'($urandom_range(0, 31)); in_neg = 5'd0;
        @(negedge clk);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      collect("rand", acc8, trit_of(acc8, int'($signed(hi8)), int'($signed(lo8))), hi8, lo8, acc6);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
